// File: rtl/seq_ctrl_pkg.sv
// Shared encodings for the sequencer: FSM states, opcodes, branch conditions and mux selects.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  // Major opcode lives in ir[31:24]; ir[19:16] carries the Bcc condition.
  localparam logic [7:0] OpNop  = 8'h00, OpLil  = 8'h01, OpMov  = 8'h02, OpAdd  = 8'h03;
  localparam logic [7:0] OpSub  = 8'h04, OpAnd  = 8'h05, OpOr   = 8'h06, OpXor  = 8'h07;
  localparam logic [7:0] OpAddi = 8'h08, OpSubi = 8'h09, OpAndi = 8'h0a, OpOri  = 8'h0b;
  localparam logic [7:0] OpXori = 8'h0c, OpNeg  = 8'h0d, OpNot  = 8'h0e, OpShl  = 8'h0f;
  localparam logic [7:0] OpShr  = 8'h10, OpSar  = 8'h11, OpCmp  = 8'h12, OpCmpi = 8'h13;
  localparam logic [7:0] OpLd   = 8'h14, OpSt   = 8'h15, OpPush = 8'h16, OpPop  = 8'h17;
  localparam logic [7:0] OpB    = 8'h18, OpBcc  = 8'h19, OpJr   = 8'h1a, OpJalr = 8'h1b;
  localparam logic [7:0] OpRet  = 8'h1c, OpHlt  = 8'h1f;

  typedef enum logic [3:0] {
    CcEq = 4'd0,
    CcNe = 4'd1,
    CcLt = 4'd2,
    CcGe = 4'd3,
    CcLe = 4'd4,
    CcGt = 4'd5
  } cc_e;

  localparam logic [1:0] PcInc = 2'd0, PcBranch = 2'd1, PcReg = 2'd2, PcPop = 2'd3;
  localparam logic [1:0] AddrPc = 2'd0, AddrAlu = 2'd1, AddrSp = 2'd2;

  // Every op that writes flags in EXEC, including the compares.
  function automatic logic is_flag_op(input logic [7:0] op);
    return (op >= OpLil) && (op <= OpCmpi);
  endfunction

  function automatic logic is_cmp(input logic [7:0] op);
    return (op == OpCmp) || (op == OpCmpi);
  endfunction

  function automatic logic is_arith(input logic [7:0] op);
    return op inside {OpAdd, OpSub, OpAddi, OpSubi, OpNeg, OpCmp, OpCmpi};
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    return is_flag_op(op) || ((op >= OpLd) && (op <= OpRet));
  endfunction

endpackage

// File: rtl/seq_ctrl_if.sv
// Control/memory handshake bundle between the sequencer and its datapath.
interface seq_ctrl_if;
  logic [31:0] ir;
  logic [31:0] dr;
  logic [1:0]  cv;        // {carry, overflow} of the ALU's 33-bit result
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic        sp_we;
  logic        sp_dec;
  logic [3:0]  flags;
  logic        halted;
  logic [2:0]  state;

  modport master (
    input  ir, dr, cv, mem_ack,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, sp_we, sp_dec, flags,
           halted, state
  );

  modport slave (
    output ir, dr, cv, mem_ack,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, sp_we, sp_dec, flags,
           halted, state
  );
endinterface

// File: rtl/seq_ctrl_cond_eval.sv
// Branch condition evaluation from the {N,Z,C,V} flags.
module seq_ctrl_cond_eval
  import seq_ctrl_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] cc_i,
  output logic       taken_o
);

  logic n, z, v, lt;
  logic unused_c;

  assign n        = flags_i[3];
  assign z        = flags_i[2];
  assign v        = flags_i[0];
  assign unused_c = flags_i[1];
  assign lt       = n ^ v;

  always_comb begin
    taken_o = 1'b0;
    case (cc_i)
      CcEq:    taken_o = z;
      CcNe:    taken_o = !z;
      CcLt:    taken_o = lt;
      CcGe:    taken_o = !lt;
      CcLe:    taken_o = z | lt;
      CcGt:    taken_o = !z & !lt;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/writeback control and flags.
module seq_ctrl
  import seq_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  seq_ctrl_if.master   bus_io
);

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [3:0]  cc_q, cc_d;
  logic [3:0]  flags_q, flags_d;
  logic        taken;
  logic        mem_req, mem_we, ir_we, pc_we, rf_we, sp_we, sp_dec;
  logic [1:0]  addr_sel, pc_sel;
  logic        unused_ir;

  assign unused_ir = ^{bus_io.ir[23:20], bus_io.ir[15:0]};

  seq_ctrl_cond_eval u_cond_eval (
    .flags_i (flags_q),
    .cc_i    (cc_q),
    .taken_o (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= OpNop;
      cc_q    <= 4'd0;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cc_q    <= cc_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cc_d     = cc_q;
    flags_d  = flags_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = AddrPc;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PcInc;
    rf_we    = 1'b0;
    sp_we    = 1'b0;
    sp_dec   = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (bus_io.mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Latch the opcode so MEM outputs stay stable whatever ir does meanwhile.
        op_d = bus_io.ir[31:24];
        cc_d = bus_io.ir[19:16];
        if (op_d == OpHlt)        state_d = StHalt;
        else if (is_known(op_d))  state_d = StExec;
        else                      state_d = StFetch;
      end
      StExec: begin
        state_d = StFetch;
        case (op_q)
          OpLd, OpSt, OpPop, OpRet: state_d = StMem;
          OpPush: begin
            sp_we   = 1'b1;
            sp_dec  = 1'b1;
            state_d = StMem;
          end
          OpB: begin
            pc_we  = 1'b1;
            pc_sel = PcBranch;
          end
          OpBcc: begin
            pc_we  = taken;
            pc_sel = PcBranch;
          end
          OpJr, OpJalr: begin
            pc_we  = 1'b1;
            pc_sel = PcReg;
            rf_we  = (op_q == OpJalr);
          end
          default: begin
            if (is_flag_op(op_q)) begin
              flags_d = {bus_io.dr[31], bus_io.dr == 32'd0,
                         is_arith(op_q) ? bus_io.cv : 2'b00};
              state_d = is_cmp(op_q) ? StFetch : StWb;
            end
          end
        endcase
      end
      StMem: begin
        mem_req  = 1'b1;
        mem_we   = (op_q == OpSt) || (op_q == OpPush);
        addr_sel = ((op_q == OpLd) || (op_q == OpSt)) ? AddrAlu : AddrSp;
        if (bus_io.mem_ack) begin
          state_d = StFetch;
          case (op_q)
            OpLd:  state_d = StWb;
            OpPop: begin
              sp_we   = 1'b1;
              state_d = StWb;
            end
            OpRet: begin
              sp_we  = 1'b1;
              pc_we  = 1'b1;
              pc_sel = PcPop;
            end
            default: state_d = StFetch;
          endcase
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Gate with rst_n so requests and strobes drop the instant reset asserts.
  assign bus_io.mem_req  = mem_req & rst_n;
  assign bus_io.mem_we   = mem_we & rst_n;
  assign bus_io.addr_sel = addr_sel;
  assign bus_io.ir_we    = ir_we & rst_n;
  assign bus_io.pc_we    = pc_we & rst_n;
  assign bus_io.pc_sel   = pc_sel;
  assign bus_io.rf_we    = rf_we & rst_n;
  assign bus_io.sp_we    = sp_we & rst_n;
  assign bus_io.sp_dec   = sp_dec;
  assign bus_io.flags    = flags_q;
  assign bus_io.halted   = (state_q == StHalt);
  assign bus_io.state    = state_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: strobe scoreboard plus latency, flag and reset checks.
module tb_seq_ctrl;
  import seq_ctrl_pkg::*;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic       sp_we;
    logic       sp_dec;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  ev_t  exp_q[$];

  seq_ctrl_if bus ();

  seq_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] cc);
    return {op, 4'h0, cc, 16'h0000};
  endfunction

  function automatic logic [3:0] model_flags(input logic [31:0] d, input logic [1:0] cv,
                                             input logic arith);
    return {d[31], d == 32'd0, arith ? cv : 2'b00};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic ir_we, input logic pc_we, input logic [1:0] pc_sel,
                      input logic rf_we, input logic sp_we, input logic sp_dec);
    exp_q.push_back('{ir_we, pc_we, pc_sel, rf_we, sp_we, sp_dec});
  endtask

  task automatic push_fetch();
    push(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Waits for the falling edge and scores any strobe seen there against the queue.
  task automatic sample();
    ev_t obs;
    ev_t exp_ev;
    @(negedge clk);
    if (bus.ir_we || bus.pc_we || bus.rf_we || bus.sp_we) begin
      obs.ir_we  = bus.ir_we;
      obs.pc_we  = bus.pc_we;
      obs.pc_sel = bus.pc_we ? bus.pc_sel : 2'd0;
      obs.rf_we  = bus.rf_we;
      obs.sp_we  = bus.sp_we;
      obs.sp_dec = bus.sp_we ? bus.sp_dec : 1'b0;
      exp_ev = '1;
      if (exp_q.size() > 0) exp_ev = exp_q.pop_front();
      total++;
      assert (obs === exp_ev) else begin
        bad++;
        $error("FAIL strobe: got=%0h want=%0h", obs, exp_ev);
      end
    end
  endtask

  // Called just after a rising edge with the DUT in FETCH; returns when FETCH or HALT recurs.
  task automatic run_instr(input string tag, input logic [31:0] instr, input logic [31:0] alu,
                           input logic [1:0] cvv, input int mem_wait,
                           input logic [1:0] exp_addr, output int cycles,
                           output int mem_cycles, output int bad_addr, output int we_cycles);
    int         req_n;
    logic [2:0] prev;
    bus.ir = instr;
    bus.dr = alu;
    bus.cv = cvv;
    cycles = 0;
    mem_cycles = 0;
    bad_addr = 0;
    we_cycles = 0;
    req_n = 0;
    prev = bus.state;
    while (cycles < 60) begin
      if (bus.state != prev) req_n = 0;
      prev = bus.state;
      bus.mem_ack = bus.mem_req && (req_n >= ((bus.state == 3'd3) ? mem_wait : 0));
      if (bus.mem_req) req_n++;
      if (bus.state == 3'd3 && bus.mem_req) begin
        mem_cycles++;
        if (bus.addr_sel != exp_addr) bad_addr++;
        if (bus.mem_we) we_cycles++;
      end
      sample();
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      cycles++;
      if (bus.state == 3'd0 || bus.state == 3'd5) break;
    end
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  int cyc, mcyc, badr, wcyc, reqs;

  initial begin
    bus.ir = 32'd0;
    bus.dr = 32'd0;
    bus.cv = 2'b00;
    bus.mem_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_state", bus.state, 3'd0);
    check("rst_flags", bus.flags, 4'd0);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("fetch_req_after_rst", bus.mem_req, 1'b1);

    // ADD with zero result.
    push_fetch(); push(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    run_instr("add0", mk(OpAdd, 4'd0), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);
    check("add0_cycles", cyc, 4);
    check("add0_flags", bus.flags, model_flags(32'd0, 2'b00, 1'b1));

    // LD with a 3-cycle late ack.
    push_fetch(); push(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    run_instr("ld", mk(OpLd, 4'd0), 32'h100, 2'b00, 3, AddrAlu, cyc, mcyc, badr, wcyc);
    check("ld_cycles", cyc, 8);
    check("ld_req_cycles", mcyc, 4);
    check("ld_addr_sel", badr, 0);
    check("ld_mem_we", wcyc, 0);

    push_fetch();
    run_instr("st", mk(OpSt, 4'd0), 32'h104, 2'b00, 0, AddrAlu, cyc, mcyc, badr, wcyc);
    check("st_cycles", cyc, 4);
    check("st_mem_we", wcyc, 1);
    check("st_addr_sel", badr, 0);

    // CMP sets Z, Bcc EQ taken.
    push_fetch();
    run_instr("cmp", mk(OpCmp, 4'd0), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);
    check("cmp_cycles", cyc, 3);
    check("cmp_flags", bus.flags, 4'b0100);
    push_fetch(); push(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    run_instr("beq_t", mk(OpBcc, CcEq), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);
    check("beq_t_cycles", cyc, 3);

    // ADD with carry out clears Z; the same Bcc EQ falls through.
    push_fetch(); push(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    run_instr("add5", mk(OpAdd, 4'd0), 32'd5, 2'b10, 0, 2'd0, cyc, mcyc, badr, wcyc);
    check("add5_flags", bus.flags, model_flags(32'd5, 2'b10, 1'b1));
    push_fetch();
    run_instr("beq_n", mk(OpBcc, CcEq), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);
    check("beq_n_cycles", cyc, 3);

    // SUB: N=1, C=1, V=1 so LT false, GE true.
    push_fetch(); push(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    run_instr("sub", mk(OpSub, 4'd0), 32'h8000_0000, 2'b11, 0, 2'd0, cyc, mcyc, badr, wcyc);
    check("sub_flags", bus.flags, model_flags(32'h8000_0000, 2'b11, 1'b1));
    push_fetch();
    run_instr("blt_n", mk(OpBcc, CcLt), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);
    push_fetch(); push(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    run_instr("bge_t", mk(OpBcc, CcGe), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);

    // XOR clears C and V even when the ALU reports them; then LE is taken via N^V.
    push_fetch(); push(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    run_instr("xor", mk(OpXor, 4'd0), 32'hf000_0000, 2'b11, 0, 2'd0, cyc, mcyc, badr, wcyc);
    check("xor_flags", bus.flags, model_flags(32'hf000_0000, 2'b11, 1'b0));
    push_fetch(); push(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    run_instr("ble_t", mk(OpBcc, CcLe), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);
    push_fetch();
    run_instr("bgt_n", mk(OpBcc, CcGt), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);

    // PUSH then POP.
    push_fetch(); push(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    run_instr("push", mk(OpPush, 4'd0), 32'd0, 2'b00, 1, AddrSp, cyc, mcyc, badr, wcyc);
    check("push_cycles", cyc, 5);
    check("push_mem_we", wcyc, 2);
    check("push_addr_sel", badr, 0);
    push_fetch(); push(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    run_instr("pop", mk(OpPop, 4'd0), 32'd0, 2'b00, 0, AddrSp, cyc, mcyc, badr, wcyc);
    check("pop_cycles", cyc, 5);
    check("pop_mem_we", wcyc, 0);
    check("pop_addr_sel", badr, 0);

    push_fetch(); push(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    run_instr("jalr", mk(OpJalr, 4'd0), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);
    check("jalr_cycles", cyc, 3);
    push_fetch(); push(1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    run_instr("ret", mk(OpRet, 4'd0), 32'd0, 2'b00, 1, AddrSp, cyc, mcyc, badr, wcyc);
    check("ret_cycles", cyc, 5);
    check("ret_addr_sel", badr, 0);

    push_fetch();
    run_instr("unknown", mk(8'hee, 4'd0), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);
    check("unknown_cycles", cyc, 2);
    check("unknown_flags_kept", bus.flags, 4'b1000);

    // Reset in the middle of a pending LD.
    push_fetch();
    bus.ir = mk(OpLd, 4'd0);
    for (int i = 0; i < 10; i++) begin
      bus.mem_ack = bus.mem_req && (bus.state == 3'd0);
      sample();
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.state == 3'd3) break;
    end
    check("midmem_state", bus.state, 3'd3);
    check("midmem_req", bus.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midmem_rst_req", bus.mem_req, 1'b0);
    check("midmem_rst_flags", bus.flags, 4'd0);
    check("midmem_rst_state", bus.state, 3'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midmem_refetch", bus.mem_req, 1'b1);

    // HLT is absorbing.
    push_fetch();
    run_instr("hlt", mk(OpHlt, 4'd0), 32'd0, 2'b00, 0, 2'd0, cyc, mcyc, badr, wcyc);
    check("hlt_cycles", cyc, 2);
    check("hlt_halted", bus.halted, 1'b1);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      bus.mem_ack = 1'b1;
      sample();
      if (bus.mem_req) reqs++;
    end
    bus.mem_ack = 1'b0;
    check("hlt_no_req", reqs, 0);
    check("hlt_state", bus.state, 3'd5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("hlt_rst_halted", bus.halted, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("hlt_rst_state", bus.state, 3'd0);
    check("hlt_rst_req", bus.mem_req, 1'b1);

    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
